// File: rtl/adc_pack_pkg.sv
// Shared types and widths for the ADC I/Q stream packer.
package adc_pack_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_e;

   localparam int SAMPLE_W = 32;
   localparam int WORD_W   = 2 * SAMPLE_W;
   localparam int OVF_W    = 32;

endpackage

// File: rtl/adc_pack_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word and valid come
// straight from flops, so there is no input-to-output combinational path.
module adc_pack_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_pop;
   logic             do_push;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign valid_o = ~empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge clk_i) begin
            if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) mem_q[gi] <= data_i;
         end
      end
   endgenerate

endmodule

// File: rtl/adc_stream_packer.sv
// Packs pairs of 32-bit ADC I/Q samples into 64-bit AXIS words, gated by a
// PPS-armed capture FSM, with a small output FIFO and drop counter.
module adc_stream_packer
   import adc_pack_pkg::*;
#(
   parameter int C_S00_AXIS_TDATA_WIDTH = SAMPLE_W,
   parameter int C_M00_AXIS_TDATA_WIDTH = WORD_W,
   parameter int FIFO_DEPTH             = 4
) (
   input  logic                              s01_axis_aclk,
   input  logic                              s01_axis_aresetn,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                              s00_axis_tvalid,
   output logic                              s00_axis_tready,
   input  logic                              enable,
   input  logic                              test_mode,
   input  logic                              pps_comp,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic                              m00_axis_tvalid,
   input  logic                              m00_axis_tready,
   output logic [OVF_W-1:0]                  overflow_count,
   output logic [1:0]                        state_o
);

   logic pps_meta_q, pps_sync_q, pps_prev_q, pps_rise_q;
   logic tready_q;

   state_e state_q, state_d;
   logic   run_entry, arm_entry, accept;

   logic                              phase_q;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] hold_q;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] word_q;
   logic                              push_q;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] pattern_q;
   logic [OVF_W-1:0]                  ovf_q;

   logic fifo_full, fifo_empty, fifo_valid, fifo_pop, drop;

   // Two-flop synchroniser followed by a registered rising-edge pulse.
   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         pps_meta_q <= 1'b0;
         pps_sync_q <= 1'b0;
         pps_prev_q <= 1'b0;
         pps_rise_q <= 1'b0;
         tready_q   <= 1'b0;
      end else begin
         pps_meta_q <= pps_comp;
         pps_sync_q <= pps_meta_q;
         pps_prev_q <= pps_sync_q;
         pps_rise_q <= pps_sync_q & ~pps_prev_q;
         tready_q   <= 1'b1;
      end
   end

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) state_q <= IDLE;
      else                   state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = ARMED;
         ARMED:   if (pps_rise_q) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = IDLE;
      endcase
      // Disable wins over a coincident PPS edge.
      if (!enable) state_d = IDLE;
   end

   assign run_entry = (state_q != RUN) && (state_d == RUN);
   assign arm_entry = (state_q == IDLE) && (state_d == ARMED);
   assign accept    = (state_q == RUN) && s00_axis_tvalid;

   // A stale half word left over from the previous run is dropped by
   // clearing the phase on the next RUN entry.
   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn) begin
         phase_q   <= 1'b0;
         hold_q    <= '0;
         word_q    <= '0;
         push_q    <= 1'b0;
         pattern_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (run_entry) begin
            phase_q   <= 1'b0;
            pattern_q <= '0;
         end else if (accept) begin
            if (!phase_q) begin
               hold_q  <= s00_axis_tdata;
               phase_q <= 1'b1;
            end else begin
               phase_q   <= 1'b0;
               push_q    <= 1'b1;
               word_q    <= test_mode ? pattern_q : {s00_axis_tdata, hold_q};
               pattern_q <= pattern_q + 1'b1;
            end
         end
      end
   end

   assign fifo_pop = ~fifo_empty & m00_axis_tready;
   assign drop     = push_q & fifo_full & ~fifo_pop;

   always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
      if (!s01_axis_aresetn)            ovf_q <= '0;
      else if (arm_entry)               ovf_q <= '0;
      else if (drop && (ovf_q != '1))   ovf_q <= ovf_q + 1'b1;
   end

   adc_pack_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (C_M00_AXIS_TDATA_WIDTH)
   ) u_fifo (
      .clk_i   (s01_axis_aclk),
      .rst_ni  (s01_axis_aresetn),
      .push_i  (push_q),
      .data_i  (word_q),
      .pop_i   (m00_axis_tready),
      .data_o  (m00_axis_tdata),
      .valid_o (fifo_valid),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign m00_axis_tvalid = fifo_valid;
   assign s00_axis_tready = tready_q;
   assign overflow_count  = ovf_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Directed bench for adc_stream_packer: a queue-based behavioural model is
// compared every cycle, plus literal expectations per scenario.
module tb_adc_stream_packer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        enable = 1'b0;
   logic        test_mode = 1'b0;
   logic        pps = 1'b0;
   logic [63:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic [31:0] ovf;
   logic [1:0]  state;

   always #5 clk = ~clk;

   adc_stream_packer #(
      .C_S00_AXIS_TDATA_WIDTH (32),
      .C_M00_AXIS_TDATA_WIDTH (64),
      .FIFO_DEPTH             (DEPTH)
   ) dut (
      .s01_axis_aclk    (clk),
      .s01_axis_aresetn (rst_n),
      .s00_axis_tdata   (s_tdata),
      .s00_axis_tvalid  (s_tvalid),
      .s00_axis_tready  (s_tready),
      .enable           (enable),
      .test_mode        (test_mode),
      .pps_comp         (pps),
      .m00_axis_tdata   (m_tdata),
      .m00_axis_tvalid  (m_tvalid),
      .m00_axis_tready  (m_tready),
      .overflow_count   (ovf),
      .state_o          (state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else
         n_pass++;
   endtask

   // Words actually handed over on the output, with the cycle they were first valid.
   logic [63:0] log_w[$];
   int          log_c[$];

   function automatic logic [63:0] logw(input int i);
      if (i < log_w.size()) return log_w[i];
      return 64'hxxxxxxxxxxxxxxxx;
   endfunction

   // ---------------- behavioural model ----------------
   logic [63:0] mq[$];
   logic [1:0]  m_state = 2'd0;
   logic        h1 = 0, h2 = 0, h3 = 0, m_rise = 0;
   logic        m_phase = 0, m_pend = 0;
   logic [31:0] m_hold = '0, m_ovf = '0;
   logic [63:0] m_cnt = '0, m_pend_w = '0;
   logic        prev_v = 0;
   logic [63:0] prev_d = '0;
   int          prev_c = 0;

   always begin : model
      logic [1:0] nxt;
      logic       rise_new;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         mq.delete();
         m_state = 2'd0; h1 = 0; h2 = 0; h3 = 0; m_rise = 0;
         m_phase = 0; m_pend = 0; m_hold = '0; m_ovf = '0; m_cnt = '0;
         prev_v = 0;
         chk("rst_tready", {63'd0, s_tready}, 64'd0);
         chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
         chk("rst_tdata", m_tdata, 64'd0);
         chk("rst_ovf", {32'd0, ovf}, 64'd0);
         chk("rst_state", {62'd0, state}, 64'd0);
      end else begin
         if (prev_v && m_tready) begin
            log_w.push_back(prev_d);
            log_c.push_back(prev_c);
            $display("xfer cycle=%0d word=%h", prev_c, prev_d);
         end
         // output buffer: drain first, then the word completed last cycle
         if ((mq.size() != 0) && m_tready) void'(mq.pop_front());
         if (m_pend) begin
            if (mq.size() < DEPTH) mq.push_back(m_pend_w);
            else if (m_ovf != 32'hFFFFFFFF) m_ovf++;
         end
         m_pend = 0;
         // pairing of samples captured while running
         if (m_state == 2'd2 && s_tvalid) begin
            if (!m_phase) begin
               m_hold  = s_tdata;
               m_phase = 1;
            end else begin
               m_pend   = 1;
               m_pend_w = test_mode ? m_cnt : {s_tdata, m_hold};
               m_cnt    = m_cnt + 64'd1;
               m_phase  = 0;
            end
         end
         nxt = m_state;
         if (m_state == 2'd0) nxt = 2'd1;
         else if (m_state == 2'd1 && m_rise) nxt = 2'd2;
         if (!enable) nxt = 2'd0;
         if (m_state == 2'd0 && nxt == 2'd1) m_ovf = '0;
         if (m_state != 2'd2 && nxt == 2'd2) begin
            m_phase = 0;
            m_cnt   = '0;
         end
         m_state = nxt;
         // PPS edge becomes visible three clocks after the input edge is sampled
         rise_new = h2 & ~h3;
         h3 = h2; h2 = h1; h1 = pps;
         m_rise = rise_new;

         chk("state", {62'd0, state}, {62'd0, m_state});
         chk("tready", {63'd0, s_tready}, 64'd1);
         chk("tvalid", {63'd0, m_tvalid}, {63'd0, (mq.size() != 0)});
         chk("ovf", {32'd0, ovf}, {32'd0, m_ovf});
         if (mq.size() != 0) chk("tdata", m_tdata, mq[0]);
         prev_v = m_tvalid;
         prev_d = m_tdata;
         prev_c = cyc;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic arm();
      @(negedge clk);
      enable = 0; pps = 0; s_tvalid = 0;
      idle(4);
      enable = 1;
      idle(2);
   endtask

   task automatic pps_go();
      pps = 1;
      idle(6);
   endtask

   task automatic send(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_tvalid = 1;
         s_tdata  = base + 32'(i);
      end
      @(negedge clk);
      s_tvalid = 0;
   endtask

   initial begin : timeout
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int c2;
      idle(3);
      chk("lit_rst_tready", {63'd0, s_tready}, 64'd0);
      chk("lit_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("lit_rst_tdata", m_tdata, 64'd0);
      chk("lit_rst_ovf", {32'd0, ovf}, 64'd0);
      chk("lit_rst_state", {62'd0, state}, 64'd0);
      rst_n = 1;
      @(negedge clk);
      chk("lit_tready_up", {63'd0, s_tready}, 64'd1);

      // basic packing and latency
      m_tready = 1;
      arm();
      pps_go();
      chk("lit_t1_run", {62'd0, state}, 64'd2);
      log_w.delete(); log_c.delete();
      @(negedge clk); s_tvalid = 1; s_tdata = 32'h1;
      @(negedge clk); s_tdata = 32'h2; c2 = cyc;
      @(negedge clk); s_tdata = 32'h3;
      @(negedge clk); s_tdata = 32'h4;
      @(negedge clk); s_tvalid = 0;
      idle(6);
      chk("lit_t1_count", 64'(log_w.size()), 64'd2);
      chk("lit_t1_w0", logw(0), 64'h0000000200000001);
      chk("lit_t1_w1", logw(1), 64'h0000000400000003);
      chk("lit_t1_lat", (log_c.size() > 0) ? 64'(log_c[0] - c2) : 64'hFFFF, 64'd2);

      // samples while armed are ignored
      arm();
      log_w.delete(); log_c.delete();
      send(32'hA1, 4);
      idle(2);
      pps_go();
      send(32'h11, 2);
      idle(6);
      chk("lit_t2_count", 64'(log_w.size()), 64'd1);
      chk("lit_t2_w0", logw(0), 64'h0000001200000011);

      // backpressure with drops
      arm();
      pps_go();
      m_tready = 0;
      log_w.delete(); log_c.delete();
      send(32'h200, 20);
      idle(3);
      chk("lit_t3_ovf", {32'd0, ovf}, 64'd6);
      chk("lit_t3_held", {63'd0, m_tvalid}, 64'd1);
      m_tready = 1;
      idle(8);
      chk("lit_t3_count", 64'(log_w.size()), 64'd4);
      for (int j = 0; j < 4; j++)
         chk("lit_t3_w", logw(j), {32'h201 + 32'(2 * j), 32'h200 + 32'(2 * j)});

      // full FIFO with a pop in the same cycle as a push: no drop
      arm();
      pps_go();
      m_tready = 0;
      log_w.delete(); log_c.delete();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); s_tvalid = 1; s_tdata = 32'h500 + 32'(i);
      end
      @(negedge clk); s_tvalid = 0; m_tready = 1;
      idle(8);
      chk("lit_t4_ovf", {32'd0, ovf}, 64'd0);
      chk("lit_t4_count", 64'(log_w.size()), 64'd5);
      chk("lit_t4_w4", logw(4), 64'h0000050900000508);

      // test pattern and restart on a new run
      test_mode = 1;
      arm();
      pps_go();
      log_w.delete(); log_c.delete();
      send(32'hDEAD0000, 8);
      idle(6);
      chk("lit_t5_count", 64'(log_w.size()), 64'd4);
      for (int j = 0; j < 4; j++) chk("lit_t5_w", logw(j), 64'(j));
      arm();
      pps_go();
      log_w.delete(); log_c.delete();
      send(32'hBEEF0000, 2);
      idle(6);
      chk("lit_t5_restart", logw(0), 64'd0);
      test_mode = 0;

      // disable after an odd number of samples
      arm();
      pps_go();
      log_w.delete(); log_c.delete();
      send(32'h301, 3);
      enable = 0;
      @(negedge clk);
      chk("lit_t6_idle", {62'd0, state}, 64'd0);
      idle(5);
      chk("lit_t6_count", 64'(log_w.size()), 64'd1);
      chk("lit_t6_w0", logw(0), 64'h0000030200000301);
      arm();
      pps_go();
      log_w.delete(); log_c.delete();
      send(32'h401, 2);
      idle(6);
      chk("lit_t6_fresh", logw(0), 64'h0000040200000401);

      // asynchronous reset with two words buffered
      arm();
      pps_go();
      m_tready = 0;
      send(32'h601, 4);
      idle(3);
      chk("lit_t7_held", {63'd0, m_tvalid}, 64'd1);
      log_w.delete(); log_c.delete();
      #2 rst_n = 0;
      #1;
      chk("lit_t7_tready", {63'd0, s_tready}, 64'd0);
      chk("lit_t7_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("lit_t7_tdata", m_tdata, 64'd0);
      chk("lit_t7_ovf", {32'd0, ovf}, 64'd0);
      chk("lit_t7_state", {62'd0, state}, 64'd0);
      idle(3);
      rst_n = 1;
      m_tready = 1;
      idle(10);
      chk("lit_t7_none", 64'(log_w.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adc_stream_packer.md
ADC_STREAM_PACKER -- requirements
Module: adc_stream_packer

Interface
REQ-001 Parameter C_S00_AXIS_TDATA_WIDTH, default 32: input sample width, 16-bit I in [15:0] and 16-bit Q in [31:16].
REQ-002 Parameter C_M00_AXIS_TDATA_WIDTH, default 64: packed output width, fixed at 2 x input width.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in words, a power of 2, minimum 2.
REQ-004 Port s01_axis_aclk, input, 1: the single clock, the ADC stream clock; all logic is in this domain.
REQ-005 Port s01_axis_aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 Port s00_axis_tdata, input, 32: ADC I/Q sample.
REQ-007 Port s00_axis_tvalid, input, 1: sample valid.
REQ-008 Port s00_axis_tready, output, 1: ready; constant 1 after reset, because the ADC cannot stall.
REQ-009 Port enable, input, 1: level; 1 arms capture, 0 stops it.
REQ-010 Port test_mode, input, 1: 1 substitutes the counter pattern for sample data.
REQ-011 Port pps_comp, input, 1: asynchronous PPS.
REQ-012 Port m00_axis_tdata, output, 64: packed word, earlier sample in [31:0], later sample in [63:32].
REQ-013 Port m00_axis_tvalid, output, 1; port m00_axis_tready, input, 1: standard AXIS handshake toward adc_to_udp_stream s01_axis.
REQ-014 Port overflow_count, output, 32: number of dropped words, saturating.
REQ-015 Port state_o, output, 2: current FSM state (IDLE=0, ARMED=1, RUN=2).

Function
REQ-016 pps_comp passes through a 2-flop synchroniser, then a rising-edge detector; pps_rise is a 1-cycle pulse 3 cycles after the input edge.
REQ-017 FSM transitions:
- IDLE -> ARMED when enable=1.
- ARMED -> RUN on pps_rise.
- Any state -> IDLE when enable=0, which takes priority over pps_rise.
REQ-018 Samples are accepted only in RUN, starting with the cycle after entry; samples in IDLE and ARMED are discarded.
REQ-019 Packing: the first accepted sample of a pair is held in [31:0]; the word is complete on the second accepted sample.
REQ-020 Pair phase resets to "first" on RUN entry.
REQ-021 A half-filled word on exit from RUN is discarded.
REQ-022 test_mode=1: a completed word is {pattern[63:32], pattern[31:0]}, i.e. the 64-bit counter value itself.
- The counter clears to 0 on RUN entry.
- It increments by 1 per completed word.
- It wraps from 2^64-1 to 0.
- test_mode is sampled per completed word.
REQ-023 A completed word is pushed to the FIFO in the cycle after its second sample.
REQ-024 Full FIFO: the word is dropped, nothing already in the FIFO is overwritten, and overflow_count increments.
- overflow_count saturates at 32'hFFFFFFFF.
- It clears only on reset or on IDLE -> ARMED.
REQ-025 Simultaneous pop (tvalid & tready) and push on a full FIFO succeeds with no drop.
REQ-026 Latency with the FIFO empty: second sample at cycle N -> m00_axis_tvalid=1 with that word at cycle N+2.
REQ-027 Once asserted, m00_axis_tvalid stays high and tdata stays stable until tready=1.
REQ-028 FIFO contents are retained on exit to IDLE and continue to drain.
REQ-029 Output order equals completion order; no word is duplicated.

Reset
REQ-030 While s01_axis_aresetn=0 the following outputs are 0: s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, overflow_count, state_o (IDLE).
REQ-031 Reset clears the FIFO pointers, pair phase, pattern counter and synchroniser flops.
REQ-032 Reset mid-packet: partial and buffered words are lost, and no spurious output appears after release.
REQ-033 s00_axis_tready rises in the first clock after reset release.

Structure
REQ-034 Package adc_pack_pkg holds:
- the state enum (IDLE, ARMED, RUN);
- sample and word width constants;
- the overflow counter width.
REQ-035 Sub-module adc_pack_fifo is a synchronous FIFO with registered output, parameterised by FIFO_DEPTH and width, providing full, empty and first-word-fall-through valid.

Verification
REQ-036 Basic packing: enable=1; PPS edge; then samples 0x00000001, 0x00000002, 0x00000003, 0x00000004 with tready=1 -> words 0x0000000200000001 and 0x0000000400000003, the first appearing 2 cycles after sample 2.
REQ-037 Arming: samples sent in ARMED before the PPS edge -> no output; the first output word contains the first two post-edge samples.
REQ-038 Backpressure: tready=0 for 20 samples at FIFO_DEPTH=4 -> 4 words held, overflow_count=6, the held words drain in order once tready=1.
REQ-039 Test mode: test_mode=1, 8 samples -> words 0, 1, 2, 3; a new RUN entry restarts at 0.
REQ-040 Disable mid-pair: enable=0 after 3 samples -> one word output; the odd sample is discarded; state_o=IDLE the next cycle.
REQ-041 Asynchronous reset asserted while the FIFO holds 2 words -> all outputs 0 immediately; no words after release.
